tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 152 +++++++++++++++
 tb/tb_tick_scheduler.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: a free-running base-tick prescaler feeding four independent
// channels. Each channel counts base ticks down from its stored period and
// emits a one-clk clock-enable pulse when the count expires. In periodic mode
// the channel reloads and keeps running; in one-shot mode it returns to IDLE.

// One scheduler channel: period/mode storage, IDLE/RUN FSM and tick down-counter.
module tick_sched_ch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         wr,
  input  logic [W-1:0] wr_period,
  input  logic         wr_oneshot,
  input  logic         start,
  input  logic         stop,
  output logic         ce,
  output logic         busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         oneshot_q, oneshot_d;
  logic         ce_q, ce_d;
  logic         busy_q, busy_d;

  // Values a start in this cycle must use: a same-cycle write to this channel
  // overrides the stored settings.
  logic [W-1:0] st_period;
  logic         st_oneshot;

  // Next-state logic: stop beats start, start beats counting, and a tick that
  // coincides with start is swallowed by the load so it is never counted.
  always_comb begin
    st_period  = wr ? wr_period  : period_q;
    st_oneshot = wr ? wr_oneshot : oneshot_q;
    period_d   = st_period;
    oneshot_d  = st_oneshot;
    state_d    = state_q;
    cnt_d      = cnt_q;
    ce_d       = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      // A zero period leaves the channel exactly as it was.
      if (st_period != '0) begin
        cnt_d   = st_period;
        state_d = RUN;
      end
    end else if (state_q == RUN && tick) begin
      if (cnt_q > W'(1)) begin
        cnt_d = cnt_q - W'(1);
      end else if (cnt_q == W'(1)) begin
        ce_d = 1'b1;
        // Reload uses the settings stored before this edge; a period that was
        // rewritten to 0 cannot be counted, so it ends the run instead.
        if (oneshot_q || period_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = period_q;
        end
      end else begin
        state_d = IDLE;
      end
    end
    busy_d = (state_d == RUN);
  end

  // Channel state register; async reset forces busy/ce low immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      ce_q      <= ce_d;
      busy_q    <= busy_d;
    end
  end

  assign ce   = ce_q;
  assign busy = busy_q;

endmodule

// Top level: shared prescaler plus an array of four channel instances.
module tick_scheduler #(
  parameter int PRESCALE = 10,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_ch,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_oneshot,
  input  logic [3:0]   start,
  input  logic [3:0]   stop,
  output logic         tick,
  output logic [3:0]   ce,
  output logic [3:0]   busy
);

  localparam int NUM_CH = 4;
  localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_wrap;

  // Prescaler wraps after PRESCALE-1; channel strobes never touch it.
  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    pre_d    = pre_wrap ? '0 : pre_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  // Gated by rst so that PRESCALE=1 still shows tick=0 during reset.
  assign tick = pre_wrap & ~rst;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_sched_ch #(.W(W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .wr         (cfg_we && (cfg_ch == 2'(g))),
      .wr_period  (cfg_period),
      .wr_oneshot (cfg_oneshot),
      .start      (start[g]),
      .stop       (stop[g]),
      .ce         (ce[g]),
      .busy       (busy[g])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=4, W=8, 10 ns clock.
// Inputs change just after a rising edge; outputs are checked on falling edges.
module tb_tick_scheduler;
  localparam int PRESCALE = 4;
  localparam int W        = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_ch = '0;
  logic [W-1:0] cfg_period = '0;
  logic         cfg_oneshot = 1'b0;
  logic [3:0]   start = '0;
  logic [3:0]   stop = '0;
  logic         tick;
  logic [3:0]   ce;
  logic [3:0]   busy;

  int n_cmp = 0;
  int n_bad = 0;
  int pc = 0;  // expected prescaler phase

  tick_scheduler #(.PRESCALE(PRESCALE), .W(W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .start(start), .stop(stop), .tick(tick), .ce(ce), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) pc <= 0;
    else     pc <= (pc + 1) % PRESCALE;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle (strobes last exactly one cycle) and check all outputs.
  task automatic step_chk(input logic [3:0] ece, input logic [3:0] ebusy, input string tag);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    start  = '0;
    stop   = '0;
    @(negedge clk);
    chk({tag, ".tick"}, {7'd0, tick}, {7'd0, (!rst && pc == PRESCALE - 1)});
    chk({tag, ".ce"},   {4'd0, ce},   {4'd0, ece});
    chk({tag, ".busy"}, {4'd0, busy}, {4'd0, ebusy});
  endtask

  task automatic wcfg(input logic [1:0] ch, input logic [W-1:0] per, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_period  = per;
    cfg_oneshot = os;
  endtask

  // Step (at most PRESCALE cycles) until the current cycle is a tick cycle.
  task automatic align(input logic [3:0] ebusy);
    for (int i = 0; i < 2 * PRESCALE && pc != PRESCALE - 1; i++) step_chk(4'b0, ebusy, "align");
    chk("align", {7'd0, pc == PRESCALE - 1}, 8'd1);
  endtask

  initial begin
    // Reset held for 20 ns
    #2;
    chk("rst.tick", {7'd0, tick}, 8'd0);
    chk("rst.ce",   {4'd0, ce},   8'd0);
    chk("rst.busy", {4'd0, busy}, 8'd0);
    step_chk(4'b0, 4'b0, "rst");
    step_chk(4'b0, 4'b0, "rst");
    rst = 1'b0;

    // Free-running tick: first at 4th cycle after release, then every 4
    for (int k = 1; k <= 9; k++) step_chk(4'b0, 4'b0, "pre");

    // Periodic ch0, period 3, start coincident with a tick (not counted);
    // rewrite to period 1 mid-run; stop on the terminal tick
    align(4'b0);
    wcfg(2'd0, 8'd3, 1'b0);
    start = 4'b0001;
    for (int k = 1; k <= 60; k++) begin
      if (k == 27) wcfg(2'd0, 8'd1, 1'b0);
      if (k == 53) stop = 4'b0001;
      step_chk((k inside {13, 25, 37, 41, 45, 49}) ? 4'b0001 : 4'b0000,
               (k <= 52) ? 4'b0001 : 4'b0000, "per");
    end

    // One-shot ch1, period 2, started off a tick cycle
    align(4'b0);
    wcfg(2'd1, 8'd2, 1'b1);
    for (int k = 1; k <= 49; k++) begin
      if (k == 2) start = 4'b0010;
      step_chk((k == 9) ? 4'b0010 : 4'b0000,
               (k >= 2 && k <= 8) ? 4'b0010 : 4'b0000, "one");
    end

    // start+stop on ch2, start with period 0 on ch3
    align(4'b0);
    wcfg(2'd2, 8'd2, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin start = 4'b1100; stop = 4'b0100; end
      step_chk(4'b0, 4'b0, "cfl");
    end

    // All four channels at period 1, simultaneous ce, then reset mid-run
    align(4'b0);
    wcfg(2'd0, 8'd1, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      if (k <= 3) wcfg(2'(k), 8'd1, 1'b0);
      if (k == 5) start = 4'hF;
      step_chk((k == 9 || k == 13) ? 4'hF : 4'h0, (k >= 5) ? 4'hF : 4'h0, "all");
    end
    rst = 1'b1;
    #1;
    chk("arst.ce",   {4'd0, ce},   8'd0);
    chk("arst.busy", {4'd0, busy}, 8'd0);
    chk("arst.tick", {7'd0, tick}, 8'd0);
    step_chk(4'b0, 4'b0, "arst");
    step_chk(4'b0, 4'b0, "arst");
    rst = 1'b0;
    start = 4'hF;
    for (int k = 1; k <= 12; k++) step_chk(4'b0, 4'b0, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
